// File: rtl/w_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : w_serializer
//  Purpose  : Parallel-to-serial front end for the downstream sequence-detector
//             FSM input `w`. Accepts WIDTH-bit words over valid/ready and emits
//             one bit per clock. A one-word holding register lets words
//             stream back to back with no idle cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module w_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_W    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             w,
    output logic             w_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // State registers and their next-state values
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             hold_full_q, hold_full_d;

    // Decoded control
    logic             accept;
    logic             last_bit;
    logic             shift_free;
    logic [WIDTH-1:0] sh_shifted;
    logic             out_bit;

    assign in_ready   = reset && !hold_full_q;
    assign accept     = in_valid && in_ready;
    assign last_bit   = active_q && (cnt_q == LAST);
    // The shifter can take a new word on the edge that retires its last bit,
    // which is what removes the bubble between consecutive words.
    assign shift_free = !active_q || last_bit;

    // Bit order only changes which end of the shifter feeds `w`.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
            assign out_bit    = sh_q[WIDTH-1];
        end else begin : g_lsb_first
            assign sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
            assign out_bit    = sh_q[0];
        end
    endgenerate

    // Next-state: held word has priority, then bypass load, then hold write.
    always_comb begin
        sh_d        = sh_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        hold_full_d = hold_full_q;

        if (shift_free && hold_full_q) begin
            sh_d     = hold_q;
            active_d = 1'b1;
            cnt_d    = '0;
            if (accept) begin
                hold_d = in_data;
            end else begin
                hold_full_d = 1'b0;
            end
        end else if (shift_free && accept) begin
            sh_d     = in_data;
            active_d = 1'b1;
            cnt_d    = '0;
        end else begin
            if (accept) begin
                hold_d      = in_data;
                hold_full_d = 1'b1;
            end
            if (active_q && !last_bit) begin
                sh_d  = sh_shifted;
                cnt_d = cnt_q + CNT_W'(1);
            end else if (last_bit) begin
                active_d = 1'b0;
            end
        end
    end

    // State register; reset discards any partial and held word immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q        <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Outputs decode from registers only.
    assign w         = active_q ? out_bit : IDLE_W;
    assign w_valid   = active_q;
    assign word_done = last_bit;
    assign busy      = active_q || hold_full_q;

`ifndef SYNTHESIS
    // The bit counter must never leave 0..WIDTH-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (int'(cnt_q) <= WIDTH - 1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/w_serializer.md
# w_serializer

Parallel-to-serial front end for the `w` input of the downstream sequence-detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `w`. A one-word holding register lets consecutive words stream with no idle cycles between them. `w_valid` marks the cycles in which `w` carries data, so the downstream FSM's reset and enable logic can track word framing.

## Interface

- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_W, 0, value driven on `w` when no data bit is being sent.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset); release is synchronous to clk by the system.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word; sampled only on an accept edge.
- in_ready  output  1  block can take a word this cycle.
- w  output  1  serial data bit to the downstream FSM.
- w_valid  output  1  `w` carries a data bit this cycle.
- word_done  output  1  `w` carries the last bit of a word this cycle.
- busy  output  1  shifter active or holding register full.

## Operation

- State elements:
  - shift register `sh` (WIDTH bits);
  - bit counter `cnt`, with ceil(log2(WIDTH)) bits;
  - `active` flag;
  - holding register `hold` (WIDTH bits);
  - `hold_full` flag.
- Accept: when `in_valid && in_ready` at a rising edge, the word is accepted. `in_ready = reset && !hold_full`.
- "Shifter free at this edge" means `!active`, or `active && cnt == WIDTH-1`.
- Load priority at each edge, evaluated in this order:
  1. If the shifter is free and `hold_full`: load `sh` from `hold`, clear `hold_full`. An accepted word goes into `hold`, which stays full.
  2. Else if the shifter is free and a word is accepted with `!hold_full`: load `sh` directly from `in_data`, bypassing `hold`.
  3. Else if a word is accepted: write `hold`, set `hold_full`.
- On any load: `active` = 1, `cnt` = 0.
- On a non-load edge with `active` and `cnt < WIDTH-1`: shift `sh` one position toward the output bit and increment `cnt`.
- On an edge with `cnt == WIDTH-1` and nothing to load: `active` = 0.
- Output bit:
  - MSB_FIRST = 1: output is `sh[WIDTH-1]`, shift left.
  - MSB_FIRST = 0: output is `sh[0]`, shift right.
- Output decode:
  - `w = active ? output bit : IDLE_W`
  - `w_valid = active`
  - `word_done = active && cnt == WIDTH-1`
  - `busy = active || hold_full`
- All outputs decode from registers only. There are no combinational paths from `in_valid` or `in_data` to any output.
- `cnt` never exceeds WIDTH-1. Any value outside 0..WIDTH-1 is unreachable, and an assertion flags it.

## Timing

- Reset asserted (reset = 0), takes effect immediately:
  - `active` = 0, `hold_full` = 0, `cnt` = 0, `sh` = 0, `hold` = 0;
  - outputs: `w` = IDLE_W, `w_valid` = 0, `word_done` = 0, `busy` = 0, `in_ready` = 0.
- Reset mid-word: the partial word and any held word are discarded. No remaining bits are emitted after release.
- First cycle after release: `in_ready` = 1.
- Latency, idle block: word accepted at edge k → its first bit is on `w` in the cycle after edge k. Its last bit is on `w`, with `word_done` = 1, in the cycle after edge k+WIDTH-1.
- Throughput: with `in_valid` held high, `w_valid` stays 1 continuously. There is no gap between words and one word completes every WIDTH cycles.
- Backpressure: `in_ready` = 0 while `hold_full`. It returns to 1 in the cycle after the edge that moves `hold` into `sh`.
- Simultaneous events:
  - Accept on the last-bit edge with `hold` empty → bypass load; no bubble.
  - Accept on the last-bit edge with `hold` full → not possible, because `in_ready` = 0.
- `in_data` is ignored when `in_valid` = 0 or `in_ready` = 0. A dropped `in_valid` never corrupts a word already in flight.

## Test plan

- Reset, then idle for 10 cycles with IDLE_W = 0 → `w` = 0, `w_valid` = 0, `busy` = 0, `in_ready` = 1 in every cycle.
- WIDTH = 8, MSB_FIRST = 1; accept 8'hB4 at edge k → `w` = 1,0,1,1,0,1,0,0 in the cycles after edges k..k+7. `word_done` = 1 only after edge k+7; then `w_valid` = 0.
- Back-to-back 8'hFF, 8'h00, 8'hA5 with `in_valid` held high → 24 consecutive cycles with `w_valid` = 1. `w` = eight 1s, eight 0s, then 1,0,1,0,0,1,0,1. `in_ready` drops after the second accept and rises when each held word is loaded.
- MSB_FIRST = 0; accept 8'h01 → `w` = 1 followed by seven 0s.
- Assert reset at bit 3 of 8'hF0 with 8'h0F held → `w_valid` = 0 and `busy` = 0 immediately. After release, no remaining bits of either word ever appear; next accept 8'h80 → `w` = 1,0,0,0,0,0,0,0.
- `in_valid` pulses for 1 cycle every 12 cycles with WIDTH = 8 → each word is serialized once, with a 4-cycle `w_valid` = 0 gap between words. `word_done` fires exactly once per word.
